// File: rtl/msg_echo_resp.sv
// Four-phase message responder: checks redundancy and destination, then echoes dat+DAT_INC back to the sender.
// Latency: i0_ack rises 2 edges after the request is sampled; o0_req rises 2 edges after i0_req is released.
// Backpressure: one message in flight; a stale high o0_ack holds off o0_req. Optional MSG_ECHO_SEQ_CHECK_EN adds a data-sequence check.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

module msg_echo_resp #(
    parameter int MY_ADDR = 10,
    parameter int DAT_INC = 1,
    parameter int ASZ     = `NS_ADDRESS_SIZE,
    parameter int DSZ     = `NS_DATA_SIZE,
    parameter int RSZ     = `NS_REDUN_SIZE
) (
    input  logic           i_clk,
    input  logic           reset,
    input  logic [ASZ-1:0] i0_src,
    input  logic [ASZ-1:0] i0_dst,
    input  logic [DSZ-1:0] i0_dat,
    input  logic [RSZ-1:0] i0_red,
    input  logic           i0_req,
    output logic           i0_ack,
    output logic [ASZ-1:0] o0_src,
    output logic [ASZ-1:0] o0_dst,
    output logic [DSZ-1:0] o0_dat,
    output logic [RSZ-1:0] o0_red,
    output logic           o0_req,
    input  logic           o0_ack,
    output logic [3:0]     dbg_leds,
    output logic [3:0]     dbg_disp0,
    output logic [3:0]     dbg_disp1
);

    localparam int MW = 2*ASZ + DSZ;

    // XOR-fold of {src,dst,dat} into RSZ-bit chunks.
    function automatic logic [RSZ-1:0] calc_redun(input logic [ASZ-1:0] s,
                                                  input logic [ASZ-1:0] d,
                                                  input logic [DSZ-1:0] x);
        logic [MW-1:0]  v;
        logic [RSZ-1:0] r;
        v = {s, d, x};
        r = '0;
        for (int k = 0; k < (MW + RSZ - 1) / RSZ; k++) begin
            r = r ^ RSZ'(v >> (k * RSZ));
        end
        return r;
    endfunction

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ACK, S_SEND, S_REL} state_t;

    state_t         state_q, state_d;
    logic [ASZ-1:0] lat_src_q, lat_src_d;
    logic [ASZ-1:0] lat_dst_q, lat_dst_d;
    logic [DSZ-1:0] lat_dat_q, lat_dat_d;
    logic [RSZ-1:0] lat_red_q, lat_red_d;
    logic           msg_ok_q, msg_ok_d;
    logic           i0_ack_q, i0_ack_d;
    logic           o0_req_q, o0_req_d;
    logic [ASZ-1:0] o0_src_q, o0_src_d;
    logic [ASZ-1:0] o0_dst_q, o0_dst_d;
    logic [DSZ-1:0] o0_dat_q, o0_dat_d;
    logic [RSZ-1:0] o0_red_q, o0_red_d;
    logic           err_red_q, err_red_d;
    logic           err_dst_q, err_dst_d;
    logic [3:0]     err_cnt_q, err_cnt_d;
    logic [DSZ-1:0] rep_cnt_q, rep_cnt_d;
    logic           busy_q, busy_d;
    logic           err_seq;

`ifdef MSG_ECHO_SEQ_CHECK_EN
    logic           err_seq_q, err_seq_d;
    logic [DSZ-1:0] last_dat_q, last_dat_d;
    logic           seen_q, seen_d;
    assign err_seq = err_seq_q;
`else
    assign err_seq = 1'b0;
`endif

    logic           red_bad, dst_bad, cnt_inc;
    logic [DSZ-1:0] reply_dat;

    assign red_bad   = lat_red_q != calc_redun(lat_src_q, lat_dst_q, lat_dat_q);
    assign dst_bad   = lat_dst_q != ASZ'(MY_ADDR);
    assign reply_dat = lat_dat_q + DSZ'(DAT_INC);

    always_comb begin
        state_d   = state_q;
        lat_src_d = lat_src_q;
        lat_dst_d = lat_dst_q;
        lat_dat_d = lat_dat_q;
        lat_red_d = lat_red_q;
        msg_ok_d  = msg_ok_q;
        i0_ack_d  = i0_ack_q;
        o0_req_d  = o0_req_q;
        o0_src_d  = o0_src_q;
        o0_dst_d  = o0_dst_q;
        o0_dat_d  = o0_dat_q;
        o0_red_d  = o0_red_q;
        err_red_d = err_red_q;
        err_dst_d = err_dst_q;
        err_cnt_d = err_cnt_q;
        rep_cnt_d = rep_cnt_q;
        cnt_inc   = 1'b0;
`ifdef MSG_ECHO_SEQ_CHECK_EN
        err_seq_d  = err_seq_q;
        last_dat_d = last_dat_q;
        seen_d     = seen_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i0_req && !i0_ack_q) begin
                    lat_src_d = i0_src;
                    lat_dst_d = i0_dst;
                    lat_dat_d = i0_dat;
                    lat_red_d = i0_red;
                    state_d   = S_CHECK;
                end
            end
            S_CHECK: begin
                err_red_d = err_red_q | red_bad;
                err_dst_d = err_dst_q | dst_bad;
                msg_ok_d  = !(red_bad || dst_bad);
                cnt_inc   = red_bad || dst_bad;
`ifdef MSG_ECHO_SEQ_CHECK_EN
                // Sequence errors still produce a reply; only valid messages advance last_dat.
                if (!(red_bad || dst_bad)) begin
                    if (seen_q && (lat_dat_q != last_dat_q + DSZ'(1))) begin
                        err_seq_d = 1'b1;
                        cnt_inc   = 1'b1;
                    end
                    last_dat_d = lat_dat_q;
                    seen_d     = 1'b1;
                end
`endif
                if (cnt_inc && (err_cnt_q != 4'hF)) begin
                    err_cnt_d = err_cnt_q + 4'd1;
                end
                i0_ack_d = 1'b1;
                state_d  = S_ACK;
            end
            S_ACK: begin
                if (!i0_req) begin
                    i0_ack_d = 1'b0;
                    if (msg_ok_q) begin
                        o0_src_d = ASZ'(MY_ADDR);
                        o0_dst_d = lat_src_q;
                        o0_dat_d = reply_dat;
                        o0_red_d = calc_redun(ASZ'(MY_ADDR), lat_src_q, reply_dat);
                        state_d  = S_SEND;
                    end else begin
                        state_d  = S_IDLE;
                    end
                end
            end
            S_SEND: begin
                if (!o0_req_q && !o0_ack) begin
                    o0_req_d = 1'b1;
                end else if (o0_req_q && o0_ack) begin
                    o0_req_d = 1'b0;
                    state_d  = S_REL;
                end
            end
            S_REL: begin
                if (!o0_ack) begin
                    rep_cnt_d = rep_cnt_q + DSZ'(1);
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = state_d != S_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            lat_src_q <= '0;
            lat_dst_q <= '0;
            lat_dat_q <= '0;
            lat_red_q <= '0;
            msg_ok_q  <= 1'b0;
            i0_ack_q  <= 1'b0;
            o0_req_q  <= 1'b0;
            o0_src_q  <= '0;
            o0_dst_q  <= '0;
            o0_dat_q  <= '0;
            o0_red_q  <= '0;
            err_red_q <= 1'b0;
            err_dst_q <= 1'b0;
            err_cnt_q <= '0;
            rep_cnt_q <= '0;
            busy_q    <= 1'b0;
`ifdef MSG_ECHO_SEQ_CHECK_EN
            err_seq_q  <= 1'b0;
            last_dat_q <= '0;
            seen_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            lat_src_q <= lat_src_d;
            lat_dst_q <= lat_dst_d;
            lat_dat_q <= lat_dat_d;
            lat_red_q <= lat_red_d;
            msg_ok_q  <= msg_ok_d;
            i0_ack_q  <= i0_ack_d;
            o0_req_q  <= o0_req_d;
            o0_src_q  <= o0_src_d;
            o0_dst_q  <= o0_dst_d;
            o0_dat_q  <= o0_dat_d;
            o0_red_q  <= o0_red_d;
            err_red_q <= err_red_d;
            err_dst_q <= err_dst_d;
            err_cnt_q <= err_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            busy_q    <= busy_d;
`ifdef MSG_ECHO_SEQ_CHECK_EN
            err_seq_q  <= err_seq_d;
            last_dat_q <= last_dat_d;
            seen_q     <= seen_d;
`endif
        end
    end

    assign i0_ack    = i0_ack_q;
    assign o0_req    = o0_req_q;
    assign o0_src    = o0_src_q;
    assign o0_dst    = o0_dst_q;
    assign o0_dat    = o0_dat_q;
    assign o0_red    = o0_red_q;
    assign dbg_leds  = {busy_q, err_seq, err_dst_q, err_red_q};
    assign dbg_disp0 = lat_dat_q[3:0];
    assign dbg_disp1 = err_cnt_q;

endmodule
